// File: rtl/mux_arbiter.sv
// Round-robin arbiter driving the select inputs of a 4:1 multiplexer.
// A rotating priority pointer gives fairness; an optional hold limit preempts long owners.
module mux_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic req2,
    input  logic req3,
    output logic grant0,
    output logic grant1,
    output logic grant2,
    output logic grant3,
    output logic address0,
    output logic address1,
    output logic busy
);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q,  last_d;
    logic [7:0] hold_q,  hold_d;

    logic [3:0] req_v;
    logic [3:0] others;
    logic [3:0] grant_v;

    // First requester found scanning upward from start, wrapping 3 -> 0.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        sel   = start;
        found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        req_v   = {req3, req2, req1, req0};
        others  = req_v & ~(4'b0001 << owner_q);
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (|req_v) begin
                    state_d = OWNED;
                    owner_d = pick(req_v, last_q + 2'd1);
                    last_d  = owner_d;
                    hold_d  = 8'd1;
                end
            end
            OWNED: begin
                if (req_v[owner_q]) begin
                    if (MAX_HOLD != 0 && hold_q >= HOLD_LIM && |others) begin
                        owner_d = pick(others, owner_q + 2'd1);
                        last_d  = owner_d;
                        hold_d  = 8'd1;
                    end else if (hold_q != 8'hFF) begin
                        hold_d = hold_q + 8'd1;
                    end
                end else if (|others) begin
                    owner_d = pick(others, owner_q + 2'd1);
                    last_d  = owner_d;
                    hold_d  = 8'd1;
                end else begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= '1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // Outputs decode registered state only, so grant and address always move together.
    assign grant_v  = (state_q == OWNED) ? (4'b0001 << owner_q) : '0;
    assign grant0   = grant_v[0];
    assign grant1   = grant_v[1];
    assign grant2   = grant_v[2];
    assign grant3   = grant_v[3];
    assign address0 = owner_q[0];
    assign address1 = owner_q[1];
    assign busy     = (state_q == OWNED);

endmodule
